// File: rtl/cva6_lsu_mem_responder_pkg.sv
// Shared constants and types for the LSU memory responder: default geometry,
// latencies, the queue entry layout and the request class encoding.
package cva6_lsu_resp_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_LOAD_LAT  = 3;
  localparam int DEF_STORE_LAT = 2;
  localparam int DEF_MAX_LAT   = (DEF_LOAD_LAT > DEF_STORE_LAT) ? DEF_LOAD_LAT : DEF_STORE_LAT;
  localparam int DEF_AGE_W     = $clog2(DEF_MAX_LAT + 1);

  typedef enum logic {
    REQ_STORE = 1'b0,
    REQ_LOAD  = 1'b1
  } req_class_e;

  // Default-sized entry; each queue instance builds the same layout from its own parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_AGE_W-1:0]  age;
  } resp_entry_t;

endpackage

// File: rtl/cva6_lsu_mem_responder_if.sv
// Request/response bundle between the issuing side and the memory responder.
interface cva6_lsu_mem_responder_if
  import cva6_lsu_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CNT_W = $clog2(2 * DEPTH) + 1;

  logic [ADDR_W-1:0] instr_i;
  logic              is_load_i;
  logic              instr_valid_i;
  logic              lsu_ready_i;
  logic              resp_stall_i;
  logic              load_mem_resp_o;
  logic              store_mem_resp_o;
  logic [ADDR_W-1:0] resp_addr_o;
  logic              load_full_o;
  logic              store_full_o;
  logic              overflow_o;
  logic [CNT_W-1:0]  outstanding_o;

  modport slave (
    input  instr_i, is_load_i, instr_valid_i, lsu_ready_i, resp_stall_i,
    output load_mem_resp_o, store_mem_resp_o, resp_addr_o,
           load_full_o, store_full_o, overflow_o, outstanding_o
  );

  modport master (
    output instr_i, is_load_i, instr_valid_i, lsu_ready_i, resp_stall_i,
    input  load_mem_resp_o, store_mem_resp_o, resp_addr_o,
           load_full_o, store_full_o, overflow_o, outstanding_o
  );

endinterface

// File: rtl/cva6_lsu_mem_responder_queue.sv
// In-order response queue for one request class: FIFO storage, per-entry
// saturating age counters and the head pop decision.
module cva6_lsu_resp_queue
  import cva6_lsu_resp_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LAT    = DEF_LOAD_LAT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [ADDR_W-1:0]       push_addr_i,
  input  logic                    stall_i,
  output logic                    pop_o,
  output logic [ADDR_W-1:0]       head_addr_o,
  output logic                    full_o,
  output logic                    drop_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(LAT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LAT);
  localparam logic [AGE_W-1:0] AGE_RDY  = AGE_W'(LAT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [AGE_W-1:0]  age;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W:0]   w_count;
  logic [PTR_W-1:0] w_off;
  logic [DEPTH-1:0] w_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_ok;
  entry_t           w_head;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == CNT_FULL);
  assign w_empty   = (w_count == CNT_ZERO);
  assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
  // The pulse is registered on the edge where the head's age reaches LAT.
  assign w_pop     = !w_empty && !stall_i && (w_head.age >= AGE_RDY);
  assign w_push_ok = push_i && (!w_full || w_pop);

  assign pop_o       = w_pop;
  assign head_addr_o = w_head.addr;
  assign full_o      = w_full;
  assign drop_o      = push_i && w_full && !w_pop;
  assign count_o     = w_count;

  // Slot occupancy: a slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_valid = {DEPTH{1'b0}};
    w_off   = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_rd_ptr[PTR_W-1:0];
      w_valid[i] = ({1'b0, w_off} < w_count);
    end
  end

  // Storage, ageing and pointer update; a push into the slot being popped wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= CNT_ZERO;
      r_rd_ptr <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {($bits(entry_t)){1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_valid[i] && (r_mem[i].age != AGE_MAX)) begin
          r_mem[i].age <= r_mem[i].age + AGE_W'(1);
        end
      end
      if (w_push_ok) begin
        r_mem[r_wr_ptr[PTR_W-1:0]].addr <= push_addr_i;
        r_mem[r_wr_ptr[PTR_W-1:0]].age  <= {AGE_W{1'b0}};
        r_wr_ptr                        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder: steers accepted LSU requests into per-class queues and
// registers the load/store response pulses plus the responding address.
module cva6_lsu_mem_responder
  import cva6_lsu_resp_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOAD_LAT  = DEF_LOAD_LAT,
  parameter int STORE_LAT = DEF_STORE_LAT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  cva6_lsu_mem_responder_if.slave  bus
);

  localparam int CNT_W  = $clog2(2 * DEPTH) + 1;
  localparam int QCNT_W = $clog2(DEPTH) + 1;

  req_class_e        w_class;
  logic              w_accept;
  logic              w_push_load;
  logic              w_push_store;
  logic              w_load_pop;
  logic              w_store_pop;
  logic              w_load_drop;
  logic              w_store_drop;
  logic              w_load_full;
  logic              w_store_full;
  logic [ADDR_W-1:0] w_load_head;
  logic [ADDR_W-1:0] w_store_head;
  logic [QCNT_W-1:0] w_load_cnt;
  logic [QCNT_W-1:0] w_store_cnt;

  logic              r_load_resp;
  logic              r_store_resp;
  logic [ADDR_W-1:0] r_resp_addr;
  logic              r_overflow;

  assign w_accept     = bus.instr_valid_i && bus.lsu_ready_i;
  assign w_class      = bus.is_load_i ? REQ_LOAD : REQ_STORE;
  assign w_push_load  = w_accept && (w_class == REQ_LOAD);
  assign w_push_store = w_accept && (w_class == REQ_STORE);

  cva6_lsu_resp_queue #(
    .DEPTH  (DEPTH),
    .LAT    (LOAD_LAT),
    .ADDR_W (ADDR_W)
  ) u_load_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push_load),
    .push_addr_i (bus.instr_i),
    .stall_i     (bus.resp_stall_i),
    .pop_o       (w_load_pop),
    .head_addr_o (w_load_head),
    .full_o      (w_load_full),
    .drop_o      (w_load_drop),
    .count_o     (w_load_cnt)
  );

  cva6_lsu_resp_queue #(
    .DEPTH  (DEPTH),
    .LAT    (STORE_LAT),
    .ADDR_W (ADDR_W)
  ) u_store_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push_store),
    .push_addr_i (bus.instr_i),
    .stall_i     (bus.resp_stall_i),
    .pop_o       (w_store_pop),
    .head_addr_o (w_store_head),
    .full_o      (w_store_full),
    .drop_o      (w_store_drop),
    .count_o     (w_store_cnt)
  );

  // Response pulses, load-priority address mux and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_load_resp  <= 1'b0;
      r_store_resp <= 1'b0;
      r_resp_addr  <= {ADDR_W{1'b0}};
      r_overflow   <= 1'b0;
    end else begin
      r_load_resp  <= w_load_pop;
      r_store_resp <= w_store_pop;
      if (w_load_pop) begin
        r_resp_addr <= w_load_head;
      end else if (w_store_pop) begin
        r_resp_addr <= w_store_head;
      end else begin
        r_resp_addr <= {ADDR_W{1'b0}};
      end
      r_overflow <= r_overflow || w_load_drop || w_store_drop;
    end
  end

  assign bus.load_mem_resp_o  = r_load_resp;
  assign bus.store_mem_resp_o = r_store_resp;
  assign bus.resp_addr_o      = r_resp_addr;
  assign bus.overflow_o       = r_overflow;
  assign bus.load_full_o      = w_load_full;
  assign bus.store_full_o     = w_store_full;
  assign bus.outstanding_o    = CNT_W'(w_load_cnt) + CNT_W'(w_store_cnt);

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Directed self-checking bench for cva6_lsu_mem_responder (DEPTH=4, LOAD_LAT=3, STORE_LAT=2).
module tb_cva6_lsu_mem_responder;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cva6_lsu_mem_responder_if #(.ADDR_W(32), .DEPTH(4)) bus ();

  cva6_lsu_mem_responder #(
    .ADDR_W    (32),
    .DEPTH     (4),
    .LOAD_LAT  (3),
    .STORE_LAT (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic [31:0] a);
    bus.instr_valid_i = v;
    bus.is_load_i     = ld;
    bus.instr_i       = a;
  endtask

  initial begin
    logic exp_p;
    rst              = 1'b1;
    bus.lsu_ready_i  = 1'b1;
    bus.resp_stall_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    check("rst_load_resp",  64'(bus.load_mem_resp_o),  64'd0);
    check("rst_store_resp", 64'(bus.store_mem_resp_o), 64'd0);
    check("rst_addr",       64'(bus.resp_addr_o),      64'd0);
    check("rst_outstanding",64'(bus.outstanding_o),    64'd0);
    check("rst_overflow",   64'(bus.overflow_o),       64'd0);
    check("rst_load_full",  64'(bus.load_full_o),      64'd0);
    check("rst_store_full", 64'(bus.store_full_o),     64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single load: pulse registered LOAD_LAT edges after acceptance
    drive(1'b1, 1'b1, 32'hcad);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("lat_out_t0",   64'(bus.outstanding_o),   64'd1);
    check("lat_pulse_t0", 64'(bus.load_mem_resp_o), 64'd0);
    tick();
    check("lat_pulse_t1", 64'(bus.load_mem_resp_o), 64'd0);
    tick();
    check("lat_pulse_t2", 64'(bus.load_mem_resp_o), 64'd0);
    tick();
    check("lat_pulse_t3", 64'(bus.load_mem_resp_o), 64'd1);
    check("lat_addr_t3",  64'(bus.resp_addr_o),     64'hcad);
    check("lat_out_t3",   64'(bus.outstanding_o),   64'd0);
    check("lat_store_t3", 64'(bus.store_mem_resp_o),64'd0);
    tick();
    check("lat_pulse_t4", 64'(bus.load_mem_resp_o), 64'd0);
    check("lat_addr_t4",  64'(bus.resp_addr_o),     64'd0);

    // Interleaved: store at s, load at s+1
    drive(1'b1, 1'b0, 32'h200);
    tick();
    drive(1'b1, 1'b1, 32'h300);
    check("il_out_s0", 64'(bus.outstanding_o), 64'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("il_out_s1",   64'(bus.outstanding_o),    64'd2);
    check("il_store_s1", 64'(bus.store_mem_resp_o), 64'd0);
    tick();
    check("il_store_s2", 64'(bus.store_mem_resp_o), 64'd1);
    check("il_load_s2",  64'(bus.load_mem_resp_o),  64'd0);
    check("il_addr_s2",  64'(bus.resp_addr_o),      64'h200);
    tick();
    check("il_store_s3", 64'(bus.store_mem_resp_o), 64'd0);
    check("il_load_s3",  64'(bus.load_mem_resp_o),  64'd0);
    tick();
    check("il_load_s4",  64'(bus.load_mem_resp_o),  64'd1);
    check("il_store_s4", 64'(bus.store_mem_resp_o), 64'd0);
    check("il_addr_s4",  64'(bus.resp_addr_o),      64'h300);
    check("il_out_s4",   64'(bus.outstanding_o),    64'd0);

    // Back-to-back stores 0x100..0x103: pulses on edges 2..5 of this window
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 32'h100 + 32'(k));
      else       drive(1'b0, 1'b0, 32'h0);
      tick();
      exp_p = (k >= 2) && (k <= 5);
      check("b2b_pulse", 64'(bus.store_mem_resp_o), 64'(exp_p));
      check("b2b_addr",  64'(bus.resp_addr_o), exp_p ? (64'h100 + 64'(k - 2)) : 64'd0);
      if (k == 3) check("b2b_out_k3", 64'(bus.outstanding_o), 64'd2);
    end
    check("b2b_out_end", 64'(bus.outstanding_o), 64'd0);

    // Stall: two loads held for six cycles, then released in order
    for (int k = 0; k < 6; k++) begin
      bus.resp_stall_i = 1'b1;
      if (k < 2) drive(1'b1, 1'b1, 32'h40 + 32'(k));
      else       drive(1'b0, 1'b0, 32'h0);
      tick();
      check("stall_no_pulse", 64'(bus.load_mem_resp_o), 64'd0);
    end
    check("stall_out", 64'(bus.outstanding_o), 64'd2);
    bus.resp_stall_i = 1'b0;
    tick();
    check("stall_rel0_pulse", 64'(bus.load_mem_resp_o), 64'd1);
    check("stall_rel0_addr",  64'(bus.resp_addr_o),     64'h40);
    tick();
    check("stall_rel1_pulse", 64'(bus.load_mem_resp_o), 64'd1);
    check("stall_rel1_addr",  64'(bus.resp_addr_o),     64'h41);
    check("stall_rel1_out",   64'(bus.outstanding_o),   64'd0);
    tick();
    check("stall_rel2_pulse", 64'(bus.load_mem_resp_o), 64'd0);

    // Full load queue: push+pop when full is legal, push without pop is dropped
    bus.resp_stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h50 + 32'(k));
      tick();
    end
    check("full_flag",     64'(bus.load_full_o),   64'd1);
    check("full_out",      64'(bus.outstanding_o), 64'd4);
    check("full_no_ovf",   64'(bus.overflow_o),    64'd0);
    bus.resp_stall_i = 1'b0;
    drive(1'b1, 1'b1, 32'h54);
    tick();
    check("pp_pulse",  64'(bus.load_mem_resp_o), 64'd1);
    check("pp_addr",   64'(bus.resp_addr_o),     64'h50);
    check("pp_out",    64'(bus.outstanding_o),   64'd4);
    check("pp_no_ovf", 64'(bus.overflow_o),      64'd0);
    check("pp_full",   64'(bus.load_full_o),     64'd1);
    bus.resp_stall_i = 1'b1;
    drive(1'b1, 1'b1, 32'h55);
    tick();
    check("ovf_pulse", 64'(bus.load_mem_resp_o), 64'd0);
    check("ovf_set",   64'(bus.overflow_o),      64'd1);
    check("ovf_out",   64'(bus.outstanding_o),   64'd4);
    bus.resp_stall_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_pulse", 64'(bus.load_mem_resp_o), 64'd1);
      check("drain_addr",  64'(bus.resp_addr_o),     64'h51 + 64'(k));
    end
    tick();
    check("drain_done",   64'(bus.load_mem_resp_o), 64'd0);
    check("drain_out",    64'(bus.outstanding_o),   64'd0);
    check("ovf_sticky",   64'(bus.overflow_o),      64'd1);
    check("drain_nofull", 64'(bus.load_full_o),     64'd0);

    // Both classes pulse together; address shows the load
    drive(1'b1, 1'b1, 32'h600);
    tick();
    drive(1'b1, 1'b0, 32'h700);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("both_early_l", 64'(bus.load_mem_resp_o),  64'd0);
    check("both_early_s", 64'(bus.store_mem_resp_o), 64'd0);
    tick();
    check("both_load",  64'(bus.load_mem_resp_o),  64'd1);
    check("both_store", 64'(bus.store_mem_resp_o), 64'd1);
    check("both_addr",  64'(bus.resp_addr_o),      64'h600);
    tick();
    check("both_after", 64'(bus.load_mem_resp_o | bus.store_mem_resp_o), 64'd0);

    // Reset mid-flight with pending entries and a pulse in progress
    drive(1'b1, 1'b1, 32'h70);
    tick();
    drive(1'b1, 1'b1, 32'h71);
    tick();
    drive(1'b1, 1'b0, 32'h80);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("mid_out", 64'(bus.outstanding_o), 64'd3);
    tick();
    check("mid_pulse", 64'(bus.load_mem_resp_o), 64'd1);
    check("mid_out2",  64'(bus.outstanding_o),   64'd2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_load",  64'(bus.load_mem_resp_o),  64'd0);
    check("arst_store", 64'(bus.store_mem_resp_o), 64'd0);
    check("arst_addr",  64'(bus.resp_addr_o),      64'd0);
    check("arst_out",   64'(bus.outstanding_o),    64'd0);
    check("arst_ovf",   64'(bus.overflow_o),       64'd0);
    tick();
    #3;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_load",  64'(bus.load_mem_resp_o),  64'd0);
      check("post_rst_store", 64'(bus.store_mem_resp_o), 64'd0);
      check("post_rst_out",   64'(bus.outstanding_o),    64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
